// File: rtl/keypad_scan_encoder.sv
// 4x3 matrix keypad scanner with frame debounce and key encoding.
// Drives active-low columns, samples rows, emits a held 4-bit key code.
module keypad_scan_encoder #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [2:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_press,
   output logic       multi_err
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      IDLE,
      CAND,
      PRESSED
   } state_t;

   logic [DW-1:0] div;
   logic [1:0]    col_idx;
   logic [1:0]    acc_n;
   logic [3:0]    acc_key;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    cand, cand_n;
   logic [3:0]    key_code_n;
   logic          key_press_n;

   logic          sample;
   logic          frame_end;
   logic [2:0]    col_hits;
   logic [3:0]    col_key;
   logic [2:0]    sum;
   logic [1:0]    tot_n;
   logic          frm_none;
   logic          frm_single;

   function automatic logic [3:0] key_map(
      input logic [1:0] r,
      input logic [1:0] c
   );
      logic [3:0] k;
      unique case ({r, c})
         4'b00_00: k = 4'd1;
         4'b00_01: k = 4'd2;
         4'b00_10: k = 4'd3;
         4'b01_00: k = 4'd4;
         4'b01_01: k = 4'd5;
         4'b01_10: k = 4'd6;
         4'b10_00: k = 4'd7;
         4'b10_01: k = 4'd8;
         4'b10_10: k = 4'd9;
         4'b11_00: k = 4'd10;
         4'b11_01: k = 4'd0;
         4'b11_10: k = 4'd11;
         default:  k = 4'd0;
      endcase
      return k;
   endfunction

   assign sample    = (div == DIV_LAST);
   assign frame_end = sample && (col_idx == 2'd2);
   assign col_out   = ~(3'b001 << col_idx);
   assign key_valid = (state == PRESSED);

   // Count closed keys in the driven column and merge with the frame so far.
   always_comb begin
      col_hits = '0;
      col_key  = acc_key;
      for (int r = 0; r < 4; r++) begin
         if (!row_in[r]) begin
            col_hits = col_hits + 3'd1;
            col_key  = key_map(2'(r), col_idx);
         end
      end
      sum        = {1'b0, acc_n} + col_hits;
      tot_n      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      frm_none   = (tot_n == 2'd0);
      frm_single = (tot_n == 2'd1);
   end

   // Column divider, column rotation and per-frame key accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         div       <= '0;
         col_idx   <= '0;
         acc_n     <= '0;
         acc_key   <= '0;
         multi_err <= 1'b0;
      end else if (sample) begin
         div     <= '0;
         col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
         if (frame_end) begin
            acc_n     <= '0;
            acc_key   <= '0;
            multi_err <= (tot_n == 2'd2);
         end else begin
            acc_n   <= tot_n;
            acc_key <= col_key;
         end
      end else begin
         div <= div + 1'b1;
      end
   end

   // Debounce state and accepted-key registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cand      <= '0;
         key_code  <= '0;
         key_press <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cand      <= cand_n;
         key_code  <= key_code_n;
         key_press <= key_press_n;
      end
   end

   // Debounce decisions, taken only on frame-end edges.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cand_n      = cand;
      key_code_n  = key_code;
      key_press_n = 1'b0;
      if (frame_end) begin
         unique case (state)
            IDLE: begin
               if (frm_single) begin
                  state_n = CAND;
                  cand_n  = col_key;
                  cnt_n   = CW'(1);
               end
            end
            CAND: begin
               if (frm_single && col_key == cand) begin
                  if (cnt + 1'b1 == CNT_LAST) begin
                     state_n     = PRESSED;
                     key_code_n  = cand;
                     key_press_n = 1'b1;
                     cnt_n       = '0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else if (frm_single) begin
                  cand_n = col_key;
                  cnt_n  = CW'(1);
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end
            PRESSED: begin
               if (frm_none) begin
                  if (cnt + 1'b1 == CNT_LAST) begin
                     state_n = IDLE;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  cnt_n = '0;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: keypad model, per-frame scoreboard,
// column pattern and pulse-width checks on every cycle.
module tb_keypad_scan_encoder;

   localparam int SD = 4;
   localparam int DB = 3;

   typedef struct {
      bit         press;
      logic [3:0] code;
      bit         valid;
      bit         merr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row_in;
   logic [2:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_press;
   logic       multi_err;

   logic [11:0] keys = '0;
   int kmap [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

   exp_t sb [$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;
   int   tb_cyc = 0;
   bit   fe = 1'b0;
   bit   armed = 1'b0;

   keypad_scan_encoder #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_SCANS (DB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_press (key_press),
      .multi_err (multi_err)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a closed key pulls its row low while its column is driven.
   always_comb begin
      row_in = 4'hf;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (keys[kmap[r][c]] && col_out[c] === 1'b0)
               row_in[r] = 1'b0;
   end

   // Independent frame position tracker.
   always @(posedge clk) begin
      if (rst) tb_cyc <= 0;
      else     tb_cyc <= (tb_cyc == 3 * SD - 1) ? 0 : tb_cyc + 1;
      fe <= !rst && (tb_cyc == 3 * SD - 1);
   end

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_col(input int cyc);
      logic [2:0] one;
      one = 3'b001;
      return ~(one << (cyc / SD));
   endfunction

   // Per-cycle checks; frame results popped from the scoreboard.
   always @(negedge clk) begin
      if (armed) begin
         chk("col_out", 16'(col_out), 16'(exp_col(tb_cyc)));
         if (fe) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 16'(1), 16'(0));
            end else begin
               e = sb.pop_front();
               chk("press", 16'(key_press), 16'(e.press));
               chk("code",  16'(key_code),  16'(e.code));
               chk("valid", 16'(key_valid), 16'(e.valid));
               chk("merr",  16'(multi_err), 16'(e.merr));
            end
         end else begin
            chk("press_gap", 16'(key_press), 16'(0));
         end
      end
   end

   task automatic run_frame(input logic [11:0] m, input bit p,
                            input logic [3:0] c, input bit v, input bit me);
      exp_t x;
      keys = m;
      x.press = p;
      x.code  = c;
      x.valid = v;
      x.merr  = me;
      sb.push_back(x);
      repeat (3 * SD) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_col"},   16'(col_out),   16'(3'b110));
      chk({tag, "_code"},  16'(key_code),  16'(0));
      chk({tag, "_valid"}, 16'(key_valid), 16'(0));
      chk({tag, "_press"}, 16'(key_press), 16'(0));
      chk({tag, "_merr"},  16'(multi_err), 16'(0));
   endtask

   initial begin
      // reset held two cycles, then idle scan
      rst  = 1'b1;
      keys = '0;
      @(posedge clk);
      #1;
      armed = 1'b1;
      chk_reset_vals("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) run_frame(12'h000, 0, 4'd0, 0, 0);

      // clean press of 5, held, then released
      run_frame(12'h020, 0, 4'd0, 0, 0);
      run_frame(12'h020, 0, 4'd0, 0, 0);
      run_frame(12'h020, 1, 4'd5, 1, 0);
      repeat (2) run_frame(12'h020, 0, 4'd5, 1, 0);
      repeat (2) run_frame(12'h000, 0, 4'd5, 1, 0);
      run_frame(12'h000, 0, 4'd5, 0, 0);

      // bouncing #
      repeat (3) begin
         run_frame(12'h800, 0, 4'd5, 0, 0);
         run_frame(12'h800, 0, 4'd5, 0, 0);
         run_frame(12'h000, 0, 4'd5, 0, 0);
         break;
      end
      run_frame(12'h800, 0, 4'd5, 0, 0);
      run_frame(12'h800, 0, 4'd5, 0, 0);
      run_frame(12'h800, 1, 4'd11, 1, 0);
      repeat (2) run_frame(12'h000, 0, 4'd11, 1, 0);
      run_frame(12'h000, 0, 4'd11, 0, 0);

      // * accepted, release interrupted, then full release
      repeat (2) run_frame(12'h400, 0, 4'd11, 0, 0);
      run_frame(12'h400, 1, 4'd10, 1, 0);
      repeat (2) run_frame(12'h000, 0, 4'd10, 1, 0);
      run_frame(12'h400, 0, 4'd10, 1, 0);
      repeat (2) run_frame(12'h000, 0, 4'd10, 1, 0);
      run_frame(12'h000, 0, 4'd10, 0, 0);

      // keys 1 and 2 together, then 1 alone
      repeat (5) run_frame(12'h006, 0, 4'd10, 0, 1);
      repeat (2) run_frame(12'h002, 0, 4'd10, 0, 0);
      run_frame(12'h002, 1, 4'd1, 1, 0);
      run_frame(12'h022, 0, 4'd1, 1, 1);
      repeat (2) run_frame(12'h000, 0, 4'd1, 1, 0);
      run_frame(12'h000, 0, 4'd1, 0, 0);

      // 0 held, reset mid-frame, debounce restarts
      repeat (2) run_frame(12'h001, 0, 4'd1, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("midrst");
      rst = 1'b0;
      repeat (2) run_frame(12'h001, 0, 4'd0, 0, 0);
      run_frame(12'h001, 1, 4'd0, 1, 0);
      run_frame(12'h001, 0, 4'd0, 1, 0);

      @(negedge clk);
      #1;
      chk("sb_left", 16'(sb.size()), 16'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
